// File: rtl/muldiv_unit.sv
// muldiv_unit: multicycle MIPS-style multiply/divide unit owning the HI/LO registers.
// MULT/MULTU use a radix-2 shift-add multiplier and DIV/DIVU a radix-2 restoring divider.
// Each runs 32 iterations plus one finish cycle, so HI/LO update 33 edges after the start edge.
// MTHI/MTLO write HI/LO in a single edge while idle.
// Optional build macro MULDIV_FAST_MUL_EN: MULT/MULTU use a single-cycle multiplier,
// with HI/LO written one edge after the start edge. Divide remains iterative.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  functcode,
    input  logic [31:0] rs_content,
    input  logic [31:0] rt_content,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MTLO  = 6'h13;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    // Shared iteration registers:
    // - Multiply: {hi_acc, lo_acc} is the partial product, and lo_acc starts as the multiplier.
    // - Divide: hi_acc is the partial remainder, and lo_acc starts as the dividend
    //   and ends as the quotient.
    logic [31:0] hi_acc;
    logic [31:0] lo_acc;
    logic [31:0] op_b;        // multiplicand or divisor magnitude
    logic [31:0] rs_raw;      // original dividend, returned in HI on divide by zero
    logic [4:0]  count;
    logic        is_div;
    logic        neg_lo;      // negate product (mul) or quotient (div)
    logic        neg_hi;      // negate remainder (div)
    logic        div_zero;

    logic        fn_muldiv;
    logic        fn_div;
    logic        fn_signed;
    logic        accept;
    logic        go_finish;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;

    logic [32:0] mul_sum;
    logic [32:0] div_trial;
    logic [63:0] raw_prod;
    logic [63:0] fix_prod;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    // Decode the issue request and form operand magnitudes for signed ops.
    assign fn_muldiv = (functcode == FN_MULT) || (functcode == FN_MULTU) ||
                       (functcode == FN_DIV)  || (functcode == FN_DIVU);
    assign fn_div    = (functcode == FN_DIV)  || (functcode == FN_DIVU);
    assign fn_signed = (functcode == FN_MULT) || (functcode == FN_DIV);
    assign accept    = (state == IDLE) && start && fn_muldiv;
    assign rs_mag    = (fn_signed && rs_content[31]) ? (32'd0 - rs_content) : rs_content;
    assign rt_mag    = (fn_signed && rt_content[31]) ? (32'd0 - rt_content) : rt_content;
    assign busy      = (state != IDLE);

`ifdef MULDIV_FAST_MUL_EN
    assign go_finish = !fn_div;
`else
    assign go_finish = 1'b0;
`endif

    // State register.
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples pre-edge values and there are no ordering races between blocks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic: IDLE -> RUN (or FINISH for fast mul) -> FINISH -> IDLE.
    // NOTE: state_next is assigned a default first, so no path through the
    // case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = go_finish ? FINISH : RUN;
            RUN:     if (count == 5'd31) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One radix-2 step: conditional add for multiply, trial subtract for divide.
    assign mul_sum   = lo_acc[0] ? ({1'b0, hi_acc} + {1'b0, op_b}) : {1'b0, hi_acc};
    assign div_trial = {hi_acc, lo_acc[31]} - {1'b0, op_b};

    // Final result with sign correction; divide by zero bypasses the datapath.
    always_comb begin
        raw_prod = {hi_acc, lo_acc};
`ifdef MULDIV_FAST_MUL_EN
        if (!is_div) raw_prod = {32'd0, lo_acc} * {32'd0, op_b};
`endif
        fix_prod = neg_lo ? (64'd0 - raw_prod) : raw_prod;
        res_hi   = fix_prod[63:32];
        res_lo   = fix_prod[31:0];
        if (is_div) begin
            if (div_zero) begin
                res_hi = rs_raw;
                res_lo = 32'hFFFF_FFFF;
            end else begin
                res_hi = neg_hi ? (32'd0 - hi_acc) : hi_acc;
                res_lo = neg_lo ? (32'd0 - lo_acc) : lo_acc;
            end
        end
    end

    // Operand latch on accept, then one iteration per RUN edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_acc   <= '0;
            lo_acc   <= '0;
            op_b     <= '0;
            rs_raw   <= '0;
            count    <= '0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        hi_acc   <= '0;
                        lo_acc   <= rs_mag;
                        op_b     <= rt_mag;
                        rs_raw   <= rs_content;
                        count    <= '0;
                        is_div   <= fn_div;
                        neg_lo   <= fn_signed && (rs_content[31] ^ rt_content[31]);
                        neg_hi   <= fn_signed && rs_content[31];
                        div_zero <= fn_div && (rt_content == 32'd0);
                    end
                end
                RUN: begin
                    count <= count + 5'd1;
                    if (is_div) begin
                        if (!div_trial[32]) begin
                            hi_acc <= div_trial[31:0];
                            lo_acc <= {lo_acc[30:0], 1'b1};
                        end else begin
                            hi_acc <= {hi_acc[30:0], lo_acc[31]};
                            lo_acc <= {lo_acc[30:0], 1'b0};
                        end
                    end else begin
                        hi_acc <= mul_sum[32:1];
                        lo_acc <= {mul_sum[0], lo_acc[31:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    // Completion pulse: high for the single cycle after leaving FINISH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) done <= 1'b0;
        else       done <= (state == FINISH);
    end

    // Architectural HI/LO: written only when leaving FINISH or by MTHI/MTLO while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            HI <= '0;
            LO <= '0;
        end else if (state == FINISH) begin
            HI <= res_hi;
            LO <= res_lo;
        end else if (state == IDLE && start) begin
            if (functcode == FN_MTHI) HI <= rs_content;
            if (functcode == FN_MTLO) LO <= rs_content;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit.
// Each issued mul/div pushes its expected HI/LO and done cycle into a scoreboard.
// A monitor pops and compares whenever done is seen.
module tb_muldiv_unit;

    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MTLO  = 6'h13;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  functcode;
    logic [31:0] rs_content;
    logic [31:0] rt_content;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    logic [31:0] mdl_hi;
    logic [31:0] mdl_lo;

    muldiv_unit dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .functcode  (functcode),
        .rs_content (rs_content),
        .rt_content (rt_content),
        .busy       (busy),
        .done       (done),
        .HI         (HI),
        .LO         (LO)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            check("done_has_expectation", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_HI"}, 64'(HI), 64'(e.hi));
                check({e.name, "_LO"}, 64'(LO), 64'(e.lo));
                check({e.name, "_latency"}, 64'(cyc), 64'(e.due));
            end
        end
    end

    // Issue one mul/div, queue its expectation and count busy cycles until idle.
    task automatic run_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input int lat,
                          input string name);
        int bc;
        bc = 0;
        @(negedge clk);
        functcode  = fn;
        rs_content = a;
        rt_content = b;
        start      = 1'b1;
        sb.push_back('{eh, el, cyc + 1 + lat, name});
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100 && busy; i++) begin
            bc++;
            @(negedge clk);
        end
        check({name, "_busy_cycles"}, 64'(bc), 64'(lat));
        mdl_hi = eh;
        mdl_lo = el;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int bc;
        reset      = 1'b1;
        start      = 1'b0;
        functcode  = 6'h00;
        rs_content = 32'h0;
        rt_content = 32'h0;
        mdl_hi     = 32'h0;
        mdl_lo     = 32'h0;

        // Reset state.
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_HI",   64'(HI),   64'd0);
        check("rst_LO",   64'(LO),   64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Multiply and divide vectors, expected values hand-computed.
        run_op(FN_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_LAT, "mult_neg3x5");
        run_op(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT, "multu_max");
        run_op(FN_MULT,  32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, MUL_LAT, "mult_maxmin");
        run_op(FN_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, MUL_LAT, "multu_shift");
        run_op(FN_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT, "div_neg7by2");
        run_op(FN_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DIV_LAT, "div_7byneg2");
        run_op(FN_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, DIV_LAT, "divu_100by7");
        run_op(FN_DIVU,  32'h0000_1234, 32'h0,         32'h0000_1234, 32'hFFFF_FFFF, DIV_LAT, "divu_by0");
        run_op(FN_DIV,   32'hFFFF_FF00, 32'h0,         32'hFFFF_FF00, 32'hFFFF_FFFF, DIV_LAT, "div_by0");
        run_op(FN_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_LAT, "div_overflow");

        // MTLO in idle: one-edge write, no busy, HI untouched.
        @(negedge clk);
        functcode  = FN_MTLO;
        rs_content = 32'hA5A5_A5A5;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mtlo_LO",   64'(LO),   64'hA5A5_A5A5);
        check("mtlo_HI",   64'(HI),   64'(mdl_hi));
        check("mtlo_busy", 64'(busy), 64'd0);
        mdl_lo = 32'hA5A5_A5A5;

        // Unsupported functcode in idle: ignored.
        @(negedge clk);
        functcode  = 6'h10;
        rs_content = 32'h5555_AAAA;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("badfn_HI",   64'(HI),   64'(mdl_hi));
        check("badfn_LO",   64'(LO),   64'(mdl_lo));
        check("badfn_busy", 64'(busy), 64'd0);

        // MTHI and MULT issued mid-DIVU: both ignored, HI gets the remainder.
        @(negedge clk);
        functcode  = FN_DIVU;
        rs_content = 32'd100;
        rt_content = 32'd7;
        start      = 1'b1;
        sb.push_back('{32'h0000_0002, 32'h0000_000E, cyc + 1 + DIV_LAT, "divu_mthi_ignored"});
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        functcode  = FN_MTHI;
        rs_content = 32'hDEAD_BEEF;
        start      = 1'b1;
        @(negedge clk);
        functcode  = FN_MULT;
        rs_content = 32'd3;
        rt_content = 32'd3;
        @(negedge clk);
        start = 1'b0;
        check("midop_HI_held", 64'(HI), 64'(mdl_hi));
        check("midop_busy",    64'(busy), 64'd1);
        for (int i = 0; i < 100 && busy; i++) @(negedge clk);
        check("divu_mthi_idle", 64'(busy), 64'd0);
        mdl_hi = 32'h0000_0002;
        mdl_lo = 32'h0000_000E;

        // Reset mid-MULT: immediate clear, no late done, start accepted on first edge after release.
        @(negedge clk);
        functcode  = FN_MULT;
        rs_content = 32'h1111_1111;
        rt_content = 32'h2222_2222;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_HI",   64'(HI),   64'd0);
        check("midrst_LO",   64'(LO),   64'd0);
        @(negedge clk);
        @(negedge clk);
        reset      = 1'b0;
        functcode  = FN_MTHI;
        rs_content = 32'h1357_9BDF;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("postrst_mthi_HI", 64'(HI), 64'h1357_9BDF);
        check("postrst_LO",      64'(LO), 64'd0);
        bc = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) bc++;
            @(negedge clk);
        end
        check("postrst_busy_cycles", 64'(bc), 64'd0);
        check("postrst_HI_held",     64'(HI), 64'h1357_9BDF);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
